// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract unit: one full-adder cell reused across all WIDTH
// operand bits, LSB first, with a start/done handshake and registered results.

module serial_adder_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Ovf
);
   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] ra;
   logic [WIDTH-1:0] rb;
   logic [WIDTH-1:0] rs;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             cell_sum;
   logic             cell_cout;

   serial_adder_ctrl_fa u_cell (
      .a  (ra[0]),
      .b  (rb[0]),
      .ci (carry),
      .s  (cell_sum),
      .co (cell_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         Sum   <= '0;
         Cout  <= 1'b0;
         Ovf   <= 1'b0;
         ra    <= '0;
         rb    <= '0;
         rs    <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry with Sub.
                  ra    <= A;
                  rb    <= B ^ {WIDTH{Sub}};
                  carry <= Sub;
                  cnt   <= '0;
                  Busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               rs    <= {cell_sum, rs[WIDTH-1:1]};
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               carry <= cell_cout;
               if (cnt == LAST) begin
                  // carry still holds the carry into the MSB here.
                  Sum   <= {cell_sum, rs[WIDTH-1:1]};
                  Cout  <= cell_cout;
                  Ovf   <= carry ^ cell_cout;
                  cnt   <= '0;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: arithmetic reference model feeds a
// queue at acceptance; a negedge monitor checks handshake timing and results.

module tb_serial_adder_ctrl;
   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   logic         clk;
   logic         rst;
   logic         Start;
   logic         Sub;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Ovf;

   int   vectors = 0;
   int   miscompares = 0;
   int   edge_no = 0;
   int   active_acc = -1000;
   res_t held = '0;
   res_t sbq[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .Start (Start),
      .Sub   (Sub),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .Done  (Done),
      .Sum   (Sum),
      .Cout  (Cout),
      .Ovf   (Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub);
      res_t r;
      int   ua, ub, sa, sb, total, stotal;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
      sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
      if (sub) begin
         total  = ua - ub;
         stotal = sa - sb;
         r.cout = (ua >= ub);
      end else begin
         total  = ua + ub;
         stotal = sa + sb;
         r.cout = (total >= (1 << W));
      end
      r.sum = W'(total);
      r.ovf = (stotal > (1 << (W - 1)) - 1) || (stotal < -(1 << (W - 1)));
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_no, act, req);
      end
   endtask

   // One clock of stimulus; the protocol model decides acceptance from cycle counts.
   task automatic step(input logic r, input logic st, input logic sb,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      rst = r; Start = st; Sub = sb; A = a; B = b;
      @(posedge clk);
      edge_no++;
      if (r) begin
         active_acc = -1000;
         sbq.delete();
         held = '0;
      end else if (st && (edge_no - active_acc >= W + 2)) begin
         sbq.push_back(ref_model(a, b, sb));
         active_acc = edge_no;
      end
      #1;
   endtask

   task automatic op(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b);
      step(1'b0, 1'b1, sb, a, b);
      for (int i = 0; i < W + 1; i++) step(1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   always @(negedge clk) begin
      if (edge_no > 0) begin
         int   d;
         res_t got;
         d = edge_no - active_acc;
         check("busy", W'(Busy), W'((d >= 0) && (d <= W - 1)));
         check("done", W'(Done), W'(d == W));
         if (Done === 1'b1) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL done_unexpected at edge %0d: got Done=1, expected no pending result", edge_no);
            end else begin
               held = sbq.pop_front();
            end
         end
         got = {Sum, Cout, Ovf};
         check("sum", got.sum, held.sum);
         check("cout", W'(got.cout), W'(held.cout));
         check("ovf", W'(got.ovf), W'(held.ovf));
      end
   end

   initial begin
      step(1'b1, 1'b1, 1'b0, '0, '0);
      step(1'b1, 1'b0, 1'b0, '0, '0);

      op(1'b0, 8'h3C, 8'h05);
      op(1'b0, 8'hFF, 8'h01);
      op(1'b0, 8'h7F, 8'h01);
      op(1'b1, 8'h05, 8'h07);
      op(1'b1, 8'h80, 8'h01);

      // Start while busy, with operands churning after acceptance.
      step(1'b0, 1'b1, 1'b0, 8'h10, 8'h20);
      step(1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      step(1'b0, 1'b0, 1'b0, 8'h10, 8'h20);
      step(1'b0, 1'b1, 1'b1, 8'hAA, 8'h55);
      for (int i = 0; i < W + 4; i++) step(1'b0, 1'b0, 1'b1, 8'hAA, 8'h55);

      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
      for (int i = 0; i < W + 2; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

      // Reset in the middle of a run, then repeat the aborted operation.
      op(1'b0, 8'h0F, 8'h01);
      step(1'b0, 1'b1, 1'b0, 8'h20, 8'h03);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h20, 8'h03);
      step(1'b1, 1'b1, 1'b0, 8'h20, 8'h03);
      step(1'b0, 1'b0, 1'b0, '0, '0);
      op(1'b0, 8'h20, 8'h03);
      step(1'b0, 1'b0, 1'b0, '0, '0);

      for (int i = 0; i < 800; i++) begin
         step(1'b0 || ($urandom_range(0, 79) == 0), $urandom_range(0, 3) == 0,
              1'($urandom), W'($urandom), W'($urandom));
      end
      for (int i = 0; i < W + 3; i++) step(1'b0, 1'b0, 1'b0, '0, '0);

      check("pending", W'(sbq.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell across all operand bits, LSB first. It accepts a WIDTH-bit operand pair and an add/subtract select through a start/done handshake. It sequences the cell for WIDTH cycles, carrying between bits through a carry flip-flop, and returns the registered sum, carry-out and signed overflow. It is the arithmetic unit the surrounding datapath uses when area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits (>= 2)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Start  in  1  request; accepted only in IDLE
- Sub  in  1  0 = A+B, 1 = A-B; sampled at acceptance
- A  in  WIDTH  operand A; sampled at acceptance
- B  in  WIDTH  operand B; sampled at acceptance
- Busy  out  1  high while bits are being processed
- Done  out  1  one-cycle pulse; result valid
- Sum  out  WIDTH  registered result; holds until the next Done
- Cout  out  1  carry out of MSB (for Sub=1: 1 = no borrow, i.e. A >= B unsigned)
- Ovf  out  1  two's-complement signed overflow

## Operation
- Exactly one full-adder cell is instantiated. No WIDTH-wide adder is permitted.
- State machine: IDLE, RUN, DONE.
- **IDLE**
  - Busy=0, Done=0.
  - On Start=1: RA<=A, RB<=B XOR {WIDTH{Sub}}, carry<=Sub, cnt<=0, go RUN.
- **RUN**
  - Busy=1.
  - Cell inputs are RA[0], RB[0] and carry.
  - Each edge: RS <= {cell_sum, RS[WIDTH-1:1]}, RA and RB shift right by one, carry<=cell_cout, cnt<=cnt+1.
  - On the cycle where cnt==WIDTH-1, the same edge also does:
    - Sum<={cell_sum, RS[WIDTH-1:1]}
    - Cout<=cell_cout
    - Ovf<=carry XOR cell_cout (carry into MSB XOR carry out of MSB)
    - go DONE
- **DONE**
  - Busy=0, Done=1 for exactly one cycle, then go IDLE.
  - Start in DONE is ignored.
- Start while Busy=1 is ignored. It does not queue and does not alter the run.
- A, B and Sub changes after acceptance have no effect on the current result.
- Sum, Cout and Ovf change only on the edge entering DONE. They are stable at all other times.
- cnt is ceil(log2(WIDTH)) bits wide and never exceeds WIDTH-1.
- Overflow/wrap rules: the sum is modulo 2^WIDTH. Carry-out and overflow are reported, never saturated.

## Timing
- **Reset** (rst=1 at an edge, any state):
  - State=IDLE, Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, RA=RB=RS=0, carry=0, cnt=0.
  - rst overrides Start on the same edge.
- **Reset mid-RUN:** aborts the run. There is no Done pulse for the aborted operation, and Sum/Cout/Ovf read 0 from the next cycle.
- **Latency:** Start is sampled high in IDLE at edge k.
  - Busy is high in cycles k+1 .. k+WIDTH (WIDTH RUN cycles).
  - Done is high in cycle k+WIDTH+1, with Sum/Cout/Ovf valid in that same cycle.
- **Throughput:** with Start held high, a new operation is accepted every WIDTH+2 cycles (RUN×WIDTH, DONE, IDLE).
- **Outputs:** Busy and Done are decoded from registered state only, with no combinational path from Start.
- **Single-cycle Start pulse:** sufficient; Start need not be held.

## Test plan
(WIDTH=8 for all scenarios.)
- **Add, no carry:** A=8'h3C, B=8'h05, Sub=0, 1-cycle Start.
  - Busy high exactly 8 cycles; Done pulse 9 cycles after the Start edge.
  - Sum=8'h41, Cout=0, Ovf=0.
- **Add, carry/overflow cases:**
  - A=8'hFF, B=8'h01 gives Sum=8'h00, Cout=1, Ovf=0.
  - A=8'h7F, B=8'h01 gives Sum=8'h80, Cout=0, Ovf=1.
- **Subtract:**
  - A=8'h05, B=8'h07, Sub=1 gives Sum=8'hFE, Cout=0, Ovf=0.
  - A=8'h80, B=8'h01, Sub=1 gives Sum=8'h7F, Cout=1, Ovf=1.
- **Start while Busy and operand churn:**
  - Start A=8'h10, B=8'h20 add.
  - At RUN cycle 3, pulse Start with A=8'hAA, B=8'h55 and hold A=8'hAA.
  - Expect a single Done with Sum=8'h30. Sum stays 8'h30 until the next accepted operation.
- **Back-to-back:** Start held high for 30 cycles with A=8'h01, B=8'h01.
  - Done pulses exactly 10 cycles apart, each with Sum=8'h02.
  - Busy is low only in the DONE and IDLE cycles.
- **Reset mid-operation:**
  - Complete A=8'h0F+8'h01 (Sum=8'h10).
  - Start A=8'h20, B=8'h03, then assert rst in RUN cycle 4.
  - Next cycle: Busy=0, Done=0, Sum=0, Cout=0, Ovf=0, and no Done for the aborted run.
  - A following Start with A=8'h20, B=8'h03 yields Sum=8'h23 after 9 cycles.
